// File: rtl/seq_multiplier_if.sv
// Handshake/operand bundle between the ALU stage (master) and the multiplier (slave).
interface seq_multiplier_if #(
   parameter int WIDTH = 32,
   parameter int SIG_W = 6
);
   logic                 start;
   logic [SIG_W-1:0]     Signal;
   logic [WIDTH-1:0]     dataA;
   logic [WIDTH-1:0]     dataB;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   dataOut;

   modport master (
      output start, Signal, dataA, dataB,
      input  busy, done, dataOut
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output busy, done, dataOut
   );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier for MULT/MULTU; signed products are formed
// from operand magnitudes and the sign is applied in the final cycle.
module seq_multiplier #(
   parameter int               WIDTH    = 32,
   parameter int               SIG_W    = 6,
   parameter logic [SIG_W-1:0] OP_MULT  = SIG_W'(24),
   parameter logic [SIG_W-1:0] OP_MULTU = SIG_W'(25)
) (
   input logic              clk,
   input logic              reset,
   seq_multiplier_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]         state_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               is_signed_reg;
   logic [WIDTH-1:0]   mag_a_reg;
   logic [2*WIDTH-1:0] p_reg;
   logic               neg_reg;
   logic [CW-1:0]      count_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [2*WIDTH-1:0] data_out_reg;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum_next;
   logic [2*WIDTH-1:0] p_next;

   // Addend is |A| gated by the current multiplier LSB.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = mag_a_reg[gi] & p_reg[0];
   end

   // The extra sum bit is the carry that is shifted back into the top of P.
   assign sum_next = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign p_next   = {sum_next, p_reg[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         is_signed_reg <= 1'b0;
         mag_a_reg     <= '0;
         p_reg         <= '0;
         neg_reg       <= 1'b0;
         count_reg     <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         data_out_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start && (bus.Signal == OP_MULT || bus.Signal == OP_MULTU)) begin
                  a_reg         <= bus.dataA;
                  b_reg         <= bus.dataB;
                  is_signed_reg <= (bus.Signal == OP_MULT);
                  busy_reg      <= 1'b1;
                  state_reg     <= LOAD;
               end
            end
            LOAD: begin
               // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
               mag_a_reg <= (is_signed_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
               p_reg     <= {{WIDTH{1'b0}},
                             (is_signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg};
               neg_reg   <= is_signed_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
               count_reg <= '0;
               state_reg <= RUN;
            end
            RUN: begin
               p_reg     <= p_next;
               count_reg <= count_reg + CW'(1);
               if (count_reg == CW'(WIDTH - 1))
                  state_reg <= FIX;
            end
            FIX: begin
               data_out_reg <= neg_reg ? -p_reg : p_reg;
               done_reg     <= 1'b1;
               busy_reg     <= 1'b0;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.dataOut = data_out_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: vector table plus handshake/reset corner sequences.
module tb_seq_multiplier;
   localparam logic [5:0] OPS = 6'd24;
   localparam logic [5:0] OPU = 6'd25;
   localparam int         LAT = 34;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seq_multiplier_if #(.WIDTH(32), .SIG_W(6)) bus ();

   seq_multiplier #(.WIDTH(32), .SIG_W(6), .OP_MULT(OPS), .OP_MULTU(OPU)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [5:0]  sig;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[9];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
      bus.start  = 1'b1;
      bus.Signal = sig;
      bus.dataA  = a;
      bus.dataB  = b;
      tick();
      bus.start  = 1'b0;
   endtask

   // Returns the number of edges after the start edge until done is seen.
   task automatic wait_done(output logic [63:0] res, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (bus.done !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL done_timeout actual=0 required=1");
      end
      res = bus.dataOut;
   endtask

   task automatic run_check(input string name, input logic [5:0] sig,
                            input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      logic [63:0] res;
      int n;
      start_op(sig, a, b);
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      wait_done(res, n);
      chk({name, "_data"}, res, exp);
      chk({name, "_lat"}, 64'(n), 64'(LAT));
      chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      $display("op sig=%0d a=%h b=%h -> %h after %0d edges", sig, a, b, res, n);
   endtask

   initial begin
      logic [63:0] res;
      int n;
      int dones;

      vecs[0] = '{OPU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      vecs[1] = '{OPS, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
      vecs[2] = '{OPS, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
      vecs[3] = '{OPS, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[4] = '{OPS, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
      vecs[5] = '{OPU, 32'h80000000, 32'd2,        64'h00000001_00000000};
      vecs[6] = '{OPS, 32'd7,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6};
      vecs[7] = '{OPU, 32'h12345678, 32'd16,       64'h00000001_23456780};
      vecs[8] = '{OPU, 32'h0,        32'hDEADBEEF, 64'h0};

      bus.start = 1'b0; bus.Signal = '0; bus.dataA = '0; bus.dataB = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_data", bus.dataOut, 64'd0);

      for (int i = 0; i < 9; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].exp);
         tick();
         chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
         chk($sformatf("vec%0d_hold", i), bus.dataOut, vecs[i].exp);
      end

      // start while busy is ignored; operand changes have no effect
      start_op(OPU, 32'd2, 32'd3);
      repeat (4) tick();
      bus.start = 1'b1; bus.Signal = OPU; bus.dataA = 32'd7; bus.dataB = 32'd6;
      tick();
      bus.start = 1'b0;
      n = 5;
      while (bus.done !== 1'b1 && n < 100) begin
         chk("busy_hold", 64'(bus.busy), 64'd1);
         tick();
         n++;
      end
      chk("busy_start_data", bus.dataOut, 64'd6);
      chk("busy_start_lat", 64'(n), 64'(LAT));
      $display("op busy-start 2*3 -> %h after %0d edges", bus.dataOut, n);
      dones = 0;
      repeat (40) begin
         tick();
         if (bus.done === 1'b1) dones++;
      end
      chk("busy_start_no_second_done", 64'(dones), 64'd0);
      chk("busy_start_idle", 64'(bus.busy), 64'd0);

      // async reset in the middle of RUN
      start_op(OPU, 32'd9, 32'd9);
      repeat (12) tick();
      reset = 1'b1;
      #1;
      chk("midreset_busy", 64'(bus.busy), 64'd0);
      chk("midreset_done", 64'(bus.done), 64'd0);
      chk("midreset_data", bus.dataOut, 64'd0);
      $display("op reset asserted mid-run");
      tick();
      reset = 1'b0;
      tick();
      run_check("after_reset", OPU, 32'd4, 32'd4, 64'd16);

      // unsupported Signal is ignored
      start_op(6'h20, 32'd5, 32'd5);
      chk("badsig_busy", 64'(bus.busy), 64'd0);
      dones = 0;
      repeat (40) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
         tick();
      end
      chk("badsig_no_activity", 64'(dones), 64'd0);
      chk("badsig_data", bus.dataOut, 64'd16);
      $display("op sig=32 ignored");
      run_check("zero", OPU, 32'd0, 32'h13579BDF, 64'd0);

      // back-to-back: start accepted in the done cycle
      run_check("b2b_first", OPU, 32'd3, 32'd5, 64'd15);
      start_op(OPU, 32'd6, 32'd7);
      chk("b2b_busy", 64'(bus.busy), 64'd1);
      wait_done(res, n);
      chk("b2b_data", res, 64'd42);
      chk("b2b_lat", 64'(n), 64'(LAT));
      $display("op back-to-back 6*7 -> %h after %0d edges", res, n);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
